// File: rtl/fifo_skew_reader.sv
// Skewed drain of a per-lane FIFO array into a systolic array.
// Lane i reads word k at step i+k. A stall on any lane freezes every lane, so the diagonal wavefront stays intact.

module fifo_skew_lane #(
  parameter int data_size = 8,
  parameter int t_width   = 13,
  parameter int lane      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 rd_block,
  input  logic [t_width-1:0]   t,
  input  logic [t_width-1:0]   len,
  input  logic                 empty,
  input  logic [data_size-1:0] lane_data,
  output logic                 stall_req,
  output logic                 r_en,
  output logic                 sys_valid,
  output logic [data_size-1:0] sys_data
);
  localparam logic [t_width-1:0] LO = t_width'(lane);

  logic act;

  assign act       = run && (t >= LO) && (t < LO + len);
  assign stall_req = act & empty;
  assign r_en      = act & ~rd_block;

  always_ff @(posedge clk) begin
    if (!rst_n) sys_valid <= 1'b0;
    else        sys_valid <= r_en;
  end

  // FIFO holds dataOut while r_en is low, so gating by the valid bit is enough
  assign sys_data = sys_valid ? lane_data : '0;
endmodule

module fifo_skew_reader #(
  parameter int data_size  = 8,
  parameter int array_size = 9,
  parameter int len_width  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [len_width-1:0]            vec_len,
  input  logic                            abort,
  input  logic                            hold,
  input  logic [array_size-1:0]           empty,
  input  logic [data_size*array_size-1:0] fifo_data,
  output logic [array_size-1:0]           r_en,
  output logic [data_size*array_size-1:0] sys_data,
  output logic [array_size-1:0]           sys_valid,
  output logic                            busy,
  output logic                            done
);
  localparam int t_width = len_width + $clog2(array_size) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [t_width-1:0]     t_q, t_d;
  logic [len_width-1:0]   len_q, len_d;
  logic [t_width-1:0]     len_ext, last_t;
  logic [array_size-1:0]  stall_req;
  logic                   run, stall, rd_block;

  assign len_ext  = {{(t_width-len_width){1'b0}}, len_q};
  assign last_t   = len_ext + t_width'(array_size - 2);
  assign run      = (state_q == S_RUN);
  assign stall    = hold | (|stall_req);
  // abort also blocks the read issued on its own edge
  assign rd_block = stall | abort;

  for (genvar i = 0; i < array_size; i++) begin : g_lane
    fifo_skew_lane #(
      .data_size(data_size),
      .t_width  (t_width),
      .lane     (i)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .rd_block (rd_block),
      .t        (t_q),
      .len      (len_ext),
      .empty    (empty[i]),
      .lane_data(fifo_data[i*data_size +: data_size]),
      .stall_req(stall_req[i]),
      .r_en     (r_en[i]),
      .sys_valid(sys_valid[i]),
      .sys_data (sys_data[i*data_size +: data_size])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            state_d = S_RUN;
            len_d   = vec_len;
            t_d     = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          t_d = t_q + t_width'(1);
          if (t_q == last_t) state_d = S_FLUSH;
        end
      end
      S_FLUSH, S_DONE: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  assign busy = (state_q != S_IDLE);
  assign done = ((state_q == S_FLUSH) || (state_q == S_DONE)) && !abort;
endmodule

// File: tb/tb_fifo_skew_reader.sv
// Bench for fifo_skew_reader: FIFO-array model, per-lane expected-word queues and per-run cycle logs.
module tb_fifo_skew_reader;
  localparam int DS = 8;
  localparam int AS = 9;
  localparam int LW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n, start, abort, hold;
  logic [LW-1:0]        vec_len;
  logic [AS-1:0]        empty, r_en, sys_valid;
  logic [DS*AS-1:0]     fifo_data, sys_data;
  logic                 busy, done;

  always #5 clk = ~clk;

  fifo_skew_reader #(.data_size(DS), .array_size(AS), .len_width(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .abort(abort), .hold(hold),
    .empty(empty), .fifo_data(fifo_data), .r_en(r_en), .sys_data(sys_data),
    .sys_valid(sys_valid), .busy(busy), .done(done)
  );

  // FIFO array: registered dataOut, held while r_en is low
  logic [7:0]    mem  [AS][256];
  logic [7:0]    rdp  [AS] = '{default: 8'd0};
  logic [7:0]    wrp  [AS];
  logic [7:0]    dout [AS] = '{default: 8'd0};
  logic [AS-1:0] force_empty;
  logic [7:0]    exp_q [AS][$];

  always @(posedge clk)
    for (int i = 0; i < AS; i++)
      if (r_en[i] && rdp[i] != wrp[i]) begin
        dout[i] <= mem[i][rdp[i]];
        rdp[i]  <= rdp[i] + 8'd1;
      end

  always_comb begin
    empty     = '0;
    fifo_data = '0;
    for (int i = 0; i < AS; i++) begin
      empty[i] = (rdp[i] == wrp[i]) | force_empty[i];
      fifo_data[i*DS +: DS] = dout[i];
    end
  end

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-run logs, indexed by cycles since the accepted start (start cycle = 0)
  int            ncyc = 0, start_cyc = 0, done_cyc = -1, done_cnt = 0, cur_len = 0;
  int            beats [AS];
  logic [AS-1:0] rlog [64];
  logic [AS-1:0] vlog [64];
  logic          blog [64];
  logic          any_ren;

  always @(negedge clk) begin
    int rel;
    logic [7:0] e;
    ncyc++;
    if (start && !busy && !abort && rst_n) begin
      start_cyc = ncyc;
      done_cyc  = -1;
      any_ren   = 1'b0;
      cur_len   = int'(vec_len);
      for (int i = 0; i < AS; i++) beats[i] = 0;
      for (int j = 0; j < 64; j++) begin rlog[j] = '0; vlog[j] = '0; blog[j] = 1'b0; end
    end
    rel = ncyc - start_cyc;
    if (rel >= 0 && rel < 64) begin
      rlog[rel] = r_en;
      vlog[rel] = sys_valid;
      blog[rel] = busy;
    end
    if (r_en != '0) any_ren = 1'b1;
    if (done) begin done_cyc = rel; done_cnt++; end
    if (rst_n) begin
      chk("rd_on_empty", 32'(r_en & empty), 0);
      for (int i = 0; i < AS; i++) begin
        if (sys_valid[i]) begin
          chk("sb_nonempty", 32'(exp_q[i].size() != 0), 1);
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk($sformatf("data_l%0d", i), 32'(sys_data[i*DS +: DS]), 32'(e));
          end
          // same step: lane i-1 is exactly one word ahead of lane i
          if (i > 0 && beats[i] < cur_len - 1) begin
            chk("skew_vld", 32'(sys_valid[i-1]), 1);
            chk("skew_idx", beats[i-1], beats[i] + 1);
          end
        end else begin
          chk("idle_data", 32'(sys_data[i*DS +: DS]), 0);
        end
      end
      for (int i = 0; i < AS; i++) if (sys_valid[i]) beats[i]++;
    end
  end

  function automatic logic [AS-1:0] exp_ren(input int t, input int len);
    logic [AS-1:0] r = '0;
    for (int i = 0; i < AS; i++) if (t >= i && t < i + len) r[i] = 1'b1;
    return r;
  endfunction

  // Expected r_en in cycle c for a run stalled for ns cycles starting at cycle s0
  function automatic logic [AS-1:0] exp_at(input int c, input int len, input int s0, input int ns);
    if (c < 1)       return '0;
    if (c < s0)      return exp_ren(c - 1, len);
    if (c < s0 + ns) return '0;
    return exp_ren(c - 1 - ns, len);
  endfunction

  task automatic check_run(input string tg, input int len, input int s0, input int ns);
    int dn = len + AS + ns;
    chk({tg, "_done"}, done_cyc, dn);
    for (int c = 0; c <= dn + 1; c++) begin
      chk({tg, "_ren"},  32'(rlog[c]), 32'(exp_at(c, len, s0, ns)));
      chk({tg, "_vld"},  32'(vlog[c]), 32'(exp_at(c - 1, len, s0, ns)));
      chk({tg, "_busy"}, 32'(blog[c]), 32'(c >= 1 && c <= dn));
    end
    for (int i = 0; i < AS; i++) chk({tg, "_drain"}, exp_q[i].size(), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int n, input int seed);
    logic [7:0] w;
    for (int i = 0; i < AS; i++)
      for (int k = 0; k < n; k++) begin
        w = 8'(seed + i * 16 + k);
        mem[i][wrp[i]] = w;
        wrp[i] = wrp[i] + 8'd1;
        exp_q[i].push_back(w);
      end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < AS; i++) begin
      wrp[i] = rdp[i];
      exp_q[i].delete();
    end
  endtask

  task automatic kick(input int len);
    vec_len = 8'(len);
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  int dc;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; vec_len = '0; force_empty = '0;
    for (int i = 0; i < AS; i++) wrp[i] = 8'd0;
    tick(2);
    chk("rst_ren", 32'(r_en), 0);
    chk("rst_vld", 32'(sys_valid), 0);
    chk("rst_data", 32'(sys_data[31:0] | sys_data[DS*AS-1:32]), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick(1);

    // basic drain, with a start mid-run that must be ignored
    preload(4, 8'h10);
    kick(4);
    tick(2);
    vec_len = 8'd9; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(17);
    check_run("t1", 4, 100, 0);

    // active lane 3 empty for two cycles at t=5
    preload(4, 8'h40);
    kick(4);
    tick(5);
    force_empty[3] = 1'b1;
    tick(2);
    force_empty = '0;
    tick(15);
    check_run("t2", 4, 6, 2);

    // downstream hold for three cycles at t=3
    preload(4, 8'h70);
    kick(4);
    tick(3);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    tick(16);
    check_run("t3", 4, 4, 3);

    // zero-length request
    dc = done_cnt;
    kick(0);
    tick(6);
    chk("t4_done", done_cyc, 1);
    chk("t4_ndone", done_cnt - dc, 1);
    chk("t4_noread", 32'(any_ren), 0);
    chk("t4_busy0", 32'(blog[0]), 0);
    chk("t4_busy1", 32'(blog[1]), 1);
    chk("t4_busy2", 32'(blog[2]), 0);

    // abort wins over a simultaneous start
    vec_len = 8'd4; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("t5_abst_busy", 32'(busy), 0);
    chk("t5_abst_ren", 32'(r_en), 0);
    tick(2);

    // abort at t=6, then a normal length-2 run
    clear_fifos();
    preload(4, 8'hA0);
    dc = done_cnt;
    kick(4);
    tick(6);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(10);
    chk("t5_ren_pre", 32'(rlog[6]), 32'(exp_ren(5, 4)));
    chk("t5_ren_abort", 32'(rlog[7]), 0);
    chk("t5_vld_after", 32'(vlog[8]), 0);
    chk("t5_busy_after", 32'(blog[8]), 0);
    chk("t5_nodone", done_cnt - dc, 0);
    clear_fifos();
    preload(2, 8'hC0);
    kick(2);
    tick(14);
    check_run("t5b", 2, 100, 0);

    // reset mid-run
    clear_fifos();
    preload(4, 8'hD0);
    kick(4);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    chk("t6_ren", 32'(r_en), 0);
    chk("t6_vld", 32'(sys_valid), 0);
    chk("t6_data", 32'(sys_data[31:0] | sys_data[DS*AS-1:32]), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    rst_n = 1'b1;
    tick(2);

    // empty on inactive lane 8 at t=0 must not stall
    clear_fifos();
    preload(4, 8'hE0);
    force_empty[8] = 1'b1;
    kick(4);
    tick(1);
    force_empty = '0;
    tick(16);
    check_run("t6b", 4, 100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
